// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 line port between an I-side reader and a D-side reader/writer.
// One transaction in flight at a time; the returned line is buffered and handed back with a single-cycle pulse.
module l2_arbiter #(
  parameter int s_addr = 32,
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [s_addr-1:0] i_addr,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_addr,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_addr,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]        state;
  logic              last_grant;  // 1 = D side won most recently
  logic              op_write;
  logic [s_addr-1:0] addr_q;
  logic [s_line-1:0] wdata_q;
  logic [s_line-1:0] line_buf;
  logic              d_req;
  logic              grant_d;
  logic              serving;

  // D wins when alone, or on a tie when I was the last winner.
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & (~i_read | ~last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_buf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            last_grant <= 1'b1;
            op_write   <= d_write;
            addr_q     <= d_addr;
            wdata_q    <= d_write ? d_wdata : '0;
          end else if (i_read) begin
            state      <= SERVE_I;
            last_grant <= 1'b0;
            op_write   <= 1'b0;
            addr_q     <= i_addr;
            wdata_q    <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            // A write returns no data, so the buffer is cleared rather than loaded.
            line_buf <= op_write ? '0 : l2_rdata;
            state    <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign serving  = (state == SERVE_I) || (state == SERVE_D);
  assign busy     = (state != IDLE);
  assign l2_read  = serving & ~op_write;
  assign l2_write = serving & op_write;
  assign l2_addr  = serving ? addr_q : '0;
  assign l2_wdata = l2_write ? wdata_q : '0;

  // last_grant still names the side being answered while in RESP.
  assign i_resp  = (state == RESP) & ~last_grant;
  assign d_resp  = (state == RESP) & last_grant;
  assign i_rdata = i_resp ? line_buf : '0;
  assign d_rdata = d_resp ? line_buf : '0;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a scoreboard queue holds the expected response side and line,
// popped by a monitor whenever a response pulse appears.
module tb_l2_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic          busy;

  always #5 clk = ~clk;

  l2_arbiter #(.s_addr(AW), .s_line(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .busy(busy)
  );

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic          side;  // 1 = D
    logic [LW-1:0] data;
  } sb_t;
  sb_t exp_q[$];
  sb_t mon_e;

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic side, input logic [LW-1:0] data);
    sb_t e;
    e.side = side;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Called in the first SERVE cycle; answers in the n-th SERVE cycle and returns in the RESP cycle.
  task automatic serve(input logic ew, input logic [AW-1:0] ea, input logic [LW-1:0] ewd,
                       input int n, input logic [LW-1:0] line);
    for (int k = 1; k <= n; k++) begin
      chk1("l2_read", l2_read, ~ew);
      chk1("l2_write", l2_write, ew);
      chkl("l2_addr", 256'(l2_addr), 256'(ea));
      chkl("l2_wdata", l2_wdata, ew ? ewd : '0);
      l2_resp  = (k == n);
      l2_rdata = (k == n) ? line : {8{32'(k) ^ 32'h5A5A_5A5A}};
      tick();
    end
    l2_resp  = 1'b0;
    l2_rdata = {8{32'hDEAD_BEEF}};
    chk1("l2_read_resp", l2_read, 1'b0);
    chk1("l2_write_resp", l2_write, 1'b0);
  endtask

  task automatic txn(input logic side, input logic rd, input logic wr, input logic [AW-1:0] addr,
                     input logic [LW-1:0] wdata, input logic [LW-1:0] line, input int n);
    logic is_wr;
    is_wr = side & wr;
    expect_resp(side, is_wr ? '0 : line);
    if (side) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_read = 1'b1; i_addr = addr;
    end
    tick();
    chk1("busy_serve", busy, 1'b1);
    // Requester inputs change after grant; L2 must keep the latched copy.
    i_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata;
    serve(is_wr, addr, wdata, n, line);
    chk1("resp_own", side ? d_resp : i_resp, 1'b1);
    chk1("resp_other", side ? i_resp : d_resp, 1'b0);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();
    chk1("busy_idle", busy, 1'b0);
    chk1("i_resp_after", i_resp, 1'b0);
    chk1("d_resp_after", d_resp, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (i_resp || d_resp) begin
        chk1("resp_exclusive", i_resp & d_resp, 1'b0);
        if (exp_q.size() == 0) begin
          chk1("resp_unexpected", i_resp | d_resp, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk1("resp_side", d_resp, mon_e.side);
          chkl("resp_rdata", mon_e.side ? d_rdata : i_rdata, mon_e.data);
        end
      end
      if (!i_resp) chkl("i_rdata_idle", i_rdata, '0);
      if (!d_resp) chkl("d_rdata_idle", d_rdata, '0);
    end
  end

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_l2_read", l2_read, 1'b0);
    chk1("rst_l2_write", l2_write, 1'b0);
    chkl("rst_l2_addr", 256'(l2_addr), '0);
    chkl("rst_l2_wdata", l2_wdata, '0);
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    chkl("rst_i_rdata", i_rdata, '0);
    chkl("rst_d_rdata", d_rdata, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Four back-to-back ties: both sides hold requests, so grants alternate D,I,D,I.
    d_read = 1'b1; d_addr = 32'h0000_8000;
    i_read = 1'b1; i_addr = 32'h0000_9000;
    for (int g = 0; g < 4; g++)
      expect_resp((g % 2) == 0, {8{32'hC0DE_0000 + 32'(g)}});
    for (int g = 0; g < 4; g++) begin
      tick();
      serve(1'b0, ((g % 2) == 0) ? 32'h0000_8000 : 32'h0000_9000, '0, 2,
            {8{32'hC0DE_0000 + 32'(g)}});
      chk1("tie_d_resp", d_resp, (g % 2) == 0);
      chk1("tie_i_resp", i_resp, (g % 2) == 1);
      if (g == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end
      tick();
      chk1("tie_busy_idle", busy, 1'b0);
    end
    tick();

    txn(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, {32{8'hAB}}, 4);
    txn(1'b1, 1'b0, 1'b1, 32'h0000_2040, {32{8'h55}}, {32{8'hEE}}, 1);
    txn(1'b1, 1'b1, 1'b1, 32'h0000_3000, {16{16'h1234}}, {32{8'h77}}, 2);
    txn(1'b1, 1'b1, 1'b0, 32'h0000_4000, {32{8'h99}}, {16{16'hBEEF}}, 3);

    // A stray L2 completion while idle must not start anything.
    l2_resp = 1'b1; l2_rdata = {32{8'h3C}};
    tick();
    chk1("stray_busy", busy, 1'b0);
    chk1("stray_i_resp", i_resp, 1'b0);
    chk1("stray_d_resp", d_resp, 1'b0);
    l2_resp = 1'b0;
    tick();

    // I drops its request after one SERVE cycle; the read still completes.
    expect_resp(1'b0, {8{32'h0BAD_F00D}});
    i_read = 1'b1; i_addr = 32'h0000_7000;
    tick();
    chk1("drop_l2_read_1", l2_read, 1'b1);
    i_read = 1'b0;
    tick();
    chk1("drop_l2_read_2", l2_read, 1'b1);
    chk1("drop_busy", busy, 1'b1);
    tick();
    chk1("drop_l2_read_3", l2_read, 1'b1);
    l2_resp = 1'b1; l2_rdata = {8{32'h0BAD_F00D}};
    tick();
    l2_resp = 1'b0;
    chk1("drop_i_resp", i_resp, 1'b1);
    tick();
    chk1("drop_busy_idle", busy, 1'b0);
    chk1("drop_i_resp_once", i_resp, 1'b0);
    tick();
    tick();

    // Reset while a D write waits on L2: everything drops at once, no response.
    d_write = 1'b1; d_addr = 32'h0000_5000; d_wdata = {32{8'h11}};
    tick();
    tick();
    chk1("rmid_l2_write", l2_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("rmid_l2_write_low", l2_write, 1'b0);
    chk1("rmid_l2_read_low", l2_read, 1'b0);
    chk1("rmid_busy_low", busy, 1'b0);
    chk1("rmid_d_resp", d_resp, 1'b0);
    d_write = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk1("rmid_idle_after", busy, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_6000, '0, {8{32'h600D_CAFE}}, 2);

    tick();
    tick();
    chkl("sb_drained", 256'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 The block SHALL have parameter s_addr, default 32, meaning physical address width in bits.
REQ-002 The block SHALL have parameter s_line, default 256, meaning cache line width in bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_read  input  1  I-side line read request, held until i_resp.
REQ-006 The block SHALL have port i_addr  input  s_addr  I-side line address.
REQ-007 The block SHALL have port i_rdata  output  s_line  I-side returned line, valid while i_resp=1.
REQ-008 The block SHALL have port i_resp  output  1  one-cycle I-side completion pulse.
REQ-009 The block SHALL have port d_read  input  1  D-side line read request, held until d_resp.
REQ-010 The block SHALL have port d_write  input  1  D-side line write request, held until d_resp.
REQ-011 The block SHALL have port d_addr  input  s_addr  D-side line address.
REQ-012 The block SHALL have port d_wdata  input  s_line  D-side write line.
REQ-013 The block SHALL have port d_rdata  output  s_line  D-side returned line, valid while d_resp=1.
REQ-014 The block SHALL have port d_resp  output  1  one-cycle D-side completion pulse.
REQ-015 The block SHALL have port l2_read, l2_write  output  1 each  L2 port command, level-held.
REQ-016 The block SHALL have port l2_addr  output  s_addr  and port l2_wdata  output  s_line, the L2 command address and data.
REQ-017 The block SHALL have port l2_rdata  input  s_line  and port l2_resp  input  1, the L2 read line and completion.
REQ-018 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, SERVE_I, SERVE_D, RESP; a last_grant register (I/D) SHALL record the most recent winner.
REQ-020 In IDLE with only one side requesting, that side SHALL be granted at the next edge.
REQ-021 In IDLE with both sides requesting, the side not equal to last_grant SHALL be granted (round-robin).
REQ-022 On grant, the op, address and wdata SHALL be latched; l2_* SHALL be driven from the latched copy, never from requester inputs.
REQ-023 l2_read/l2_write SHALL assert in the first cycle of SERVE_x and hold until the cycle l2_resp=1, then deassert at the next edge.
REQ-024 d_read and d_write both high at grant SHALL be treated as a write; I-side SHALL never produce l2_write.
REQ-025 On l2_resp in SERVE_x, l2_rdata SHALL be captured into a line buffer and the FSM SHALL enter RESP.
REQ-026 In RESP, exactly one x_resp SHALL pulse for one cycle, with x_rdata = buffer; the FSM SHALL then return to IDLE.
REQ-027 Minimum latency SHALL be 3 cycles from request sample to x_resp, with l2_resp in the first SERVE cycle; otherwise it SHALL be 2 + L2 wait cycles.
REQ-028 A requester dropping its request mid-transaction SHALL NOT abort it; the L2 op SHALL complete and x_resp SHALL still pulse.
REQ-029 Requests sampled in RESP SHALL be ignored; arbitration SHALL occur only in IDLE.
REQ-030 x_rdata SHALL be 0 whenever x_resp=0; l2_wdata SHALL be 0 for reads.
REQ-031 l2_resp arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, last_grant=I (so D wins the first tie), all outputs 0, buffers and latches 0.
REQ-033 Reset asserted mid-transaction SHALL drop the transaction without any x_resp; after release the block SHALL wait in IDLE for new requests.

Verification
REQ-034 I-only read 0x0000_1000, l2_resp after 4 cycles with line 0xAB.. -> l2_read high 4 cycles, i_resp one cycle later with i_rdata=0xAB.., d_resp never pulses.
REQ-035 D and I both requesting after reset -> D served first, then I; a second tie after that -> D first again (alternation verified across 4 ties).
REQ-036 D write 0x0000_2040 with d_wdata=0x55.., l2_resp in the first cycle -> l2_write one cycle, l2_wdata=0x55.., d_resp 3 cycles after request, d_rdata=0.
REQ-037 d_read=d_write=1 -> l2_write issued, l2_read stays 0.
REQ-038 rst pulled low while SERVE_D waits -> l2_write/l2_read/busy go 0 asynchronously, no d_resp; post-release I read completes normally.
REQ-039 I drops i_read after one SERVE cycle -> l2_read still held until l2_resp, i_resp still pulses once.
